// File: rtl/vga_frame_update_ctrl.sv
// Frame-synchronous shadow register file for the VGA pointer memory: CPU writes
// are buffered with dirty bits and replayed one per cycle on each VSync or force.
module vga_frame_update_ctrl #(
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   NUM_REGS     = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Port_ID,
  input  logic [7:0] IN_DATA,
  input  logic       WRITE_STROBE,
  input  logic       READ_STROBE,
  input  logic       CS_VGA,
  output logic [7:0] OUT_DATA,
  input  logic       VSync,
  output logic [3:0] MemAddrOut,
  output logic [7:0] MemDataIN,
  output logic       MemWE,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state;
  logic [7:0]          shadow [NUM_REGS];
  logic [NUM_REGS-1:0] dirty;
  logic [NUM_REGS-1:0] dirty_nxt;
  logic [3:0]          k;
  logic [5:0]          frame_count;
  logic                vs_q;

  logic       cpu_wr;
  logic       shadow_wr;
  logic       ctrl_wr;
  logic       force_cmd;
  logic       clear_cmd;
  logic       vs_edge;
  logic       trigger;
  logic       pending;
  logic [7:0] status;
  logic [7:0] rd_data;

  // Reads are non-destructive, so the read strobe carries no information here.
  logic unused_inputs;
  assign unused_inputs = ^{READ_STROBE, Port_ID[7:5]};

  always_comb begin
    cpu_wr    = CS_VGA & WRITE_STROBE;
    shadow_wr = cpu_wr & ~Port_ID[4];
    ctrl_wr   = cpu_wr & (Port_ID[4:0] == 5'h10) & (state == IDLE);
    force_cmd = ctrl_wr & IN_DATA[0];
    clear_cmd = ctrl_wr & IN_DATA[1];
    vs_edge   = (vs_q != VSYNC_ACTIVE) && (VSync == VSYNC_ACTIVE);
    trigger   = (state == IDLE) & (vs_edge | force_cmd);
    pending   = |dirty;
    status    = {frame_count, pending, Busy};
  end

  // A CPU write to the entry being scanned keeps its dirty bit: set beats clear.
  always_comb begin
    dirty_nxt = dirty;
    if (clear_cmd)
      dirty_nxt = '0;
    if (state == SCAN)
      dirty_nxt[k] = 1'b0;
    if (shadow_wr)
      dirty_nxt[Port_ID[3:0]] = 1'b1;
  end

  always_comb begin
    rd_data = 8'h00;
    if (!Port_ID[4])
      rd_data = shadow[Port_ID[3:0]];
    else if (Port_ID[3:0] == 4'h0)
      rd_data = status;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++)
        shadow[i] <= 8'h00;
    end else if (shadow_wr) begin
      shadow[Port_ID[3:0]] <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      OUT_DATA <= 8'h00;
    else if (CS_VGA)
      OUT_DATA <= rd_data;
  end

  // The SCAN entry cycle is not yet Busy; Busy covers exactly the 16 emit edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      k           <= 4'd0;
      Busy        <= 1'b0;
      MemWE       <= 1'b0;
      MemAddrOut  <= 4'd0;
      MemDataIN   <= 8'h00;
      frame_count <= 6'd0;
      vs_q        <= ~VSYNC_ACTIVE;
      dirty       <= '0;
    end else begin
      vs_q  <= VSync;
      dirty <= dirty_nxt;
      MemWE <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= SCAN;
            k     <= 4'd0;
          end
        end
        SCAN: begin
          Busy  <= 1'b1;
          MemWE <= dirty[k];
          if (dirty[k]) begin
            MemAddrOut <= k;
            MemDataIN  <= shadow[k];
          end
          k <= k + 4'd1;
          if (k == 4'd15)
            state <= DONE;
        end
        DONE: begin
          Busy        <= 1'b0;
          frame_count <= frame_count + 6'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_update_ctrl.sv
// Directed bench for vga_frame_update_ctrl: commit passes, collisions,
// control commands, frame counter wrap and mid-pass reset.
module tb_vga_frame_update_ctrl;

  logic       CLK;
  logic       RESET;
  logic [7:0] Port_ID;
  logic [7:0] IN_DATA;
  logic       WRITE_STROBE;
  logic       READ_STROBE;
  logic       CS_VGA;
  logic [7:0] OUT_DATA;
  logic       VSync;
  logic [3:0] MemAddrOut;
  logic [7:0] MemDataIN;
  logic       MemWE;
  logic       Busy;

  int         n_checks;
  int         n_fail;
  int         exp_frame;
  logic [7:0] exp_data [16];

  vga_frame_update_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Port_ID      (Port_ID),
    .IN_DATA      (IN_DATA),
    .WRITE_STROBE (WRITE_STROBE),
    .READ_STROBE  (READ_STROBE),
    .CS_VGA       (CS_VGA),
    .OUT_DATA     (OUT_DATA),
    .VSync        (VSync),
    .MemAddrOut   (MemAddrOut),
    .MemDataIN    (MemDataIN),
    .MemWE        (MemWE),
    .Busy         (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] status_exp(input logic pend);
    logic [5:0] f;
    f = exp_frame[5:0];
    return {f, pend, 1'b0};
  endfunction

  task automatic cpu_write(input logic [7:0] port, input logic [7:0] data);
    Port_ID = port; IN_DATA = data; CS_VGA = 1'b1; WRITE_STROBE = 1'b1;
    tick();
    CS_VGA = 1'b0; WRITE_STROBE = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] port, input logic [7:0] exp);
    Port_ID = port; CS_VGA = 1'b1; READ_STROBE = 1'b1;
    tick();
    CS_VGA = 1'b0; READ_STROBE = 1'b0;
    check(tag, 32'(OUT_DATA), 32'(exp));
  endtask

  // Trigger a pass (VSync edge or control write) and check every emit cycle;
  // col_k >= 0 injects a CPU write to entry col_k in the cycle that scans it.
  task automatic run_pass(input bit use_force, input logic [7:0] ctrl,
                          input logic [15:0] exp_we, input int col_k,
                          input logic [7:0] col_d);
    if (use_force) begin
      Port_ID = 8'h10; IN_DATA = ctrl; CS_VGA = 1'b1; WRITE_STROBE = 1'b1;
    end else begin
      VSync = 1'b0;
    end
    tick();
    CS_VGA = 1'b0; WRITE_STROBE = 1'b0; VSync = 1'b1;
    check("busy_pre", 32'(Busy), 0);
    for (int j = 0; j < 16; j++) begin
      if (j == col_k) begin
        Port_ID = j[7:0]; IN_DATA = col_d; CS_VGA = 1'b1; WRITE_STROBE = 1'b1;
      end
      tick();
      CS_VGA = 1'b0; WRITE_STROBE = 1'b0;
      check("busy", 32'(Busy), 1);
      check("memwe", 32'(MemWE), 32'(exp_we[j]));
      if (exp_we[j]) begin
        check("memaddr", 32'(MemAddrOut), j);
        check("memdata", 32'(MemDataIN), 32'(exp_data[j]));
      end
    end
    tick();
    check("busy_post", 32'(Busy), 0);
    exp_frame++;
  endtask

  task automatic quick_pass();
    cpu_write(8'h10, 8'h01);
    for (int j = 0; j < 17; j++) tick();
    check("qbusy", 32'(Busy), 0);
    exp_frame++;
  endtask

  initial begin
    int pulses;
    n_checks = 0; n_fail = 0; exp_frame = 0;
    RESET = 1'b1; Port_ID = 8'h00; IN_DATA = 8'h00; WRITE_STROBE = 1'b0;
    READ_STROBE = 1'b0; CS_VGA = 1'b0; VSync = 1'b1;
    for (int i = 0; i < 16; i++) exp_data[i] = 8'h00;
    tick(); tick();
    RESET = 1'b0;
    tick();
    check("rst_out_data", 32'(OUT_DATA), 0);
    check("rst_memaddr", 32'(MemAddrOut), 0);
    check("rst_memdata", 32'(MemDataIN), 0);
    check("rst_memwe", 32'(MemWE), 0);
    check("rst_busy", 32'(Busy), 0);
    read_chk("rst_status", 8'h10, 8'h00);

    // Single dirty entry committed on a VSync edge
    cpu_write(8'h05, 8'h3C);
    read_chk("t1_pending", 8'h10, 8'h02);
    read_chk("t1_readback", 8'h05, 8'h3C);
    exp_data[5] = 8'h3C;
    run_pass(1'b0, 8'h00, 16'h0020, -1, 8'h00);
    check("t1_hold_addr", 32'(MemAddrOut), 5);
    check("t1_hold_data", 32'(MemDataIN), 'h3C);
    read_chk("t1_status", 8'h10, 8'h04);
    read_chk("t1_unmapped", 8'h15, 8'h00);

    // Three entries committed by a force command, then an empty VSync pass
    cpu_write(8'h00, 8'hA0);
    cpu_write(8'h07, 8'hA7);
    cpu_write(8'h0F, 8'hAF);
    exp_data[0] = 8'hA0; exp_data[7] = 8'hA7; exp_data[15] = 8'hAF;
    run_pass(1'b1, 8'h01, 16'h8081, -1, 8'h00);
    read_chk("t2_status", 8'h10, status_exp(1'b0));
    run_pass(1'b0, 8'h00, 16'h0000, -1, 8'h00);
    read_chk("t2_status2", 8'h10, status_exp(1'b0));

    // Write to entry 9 in the very cycle it is scanned
    cpu_write(8'h09, 8'h11);
    exp_data[9] = 8'h11;
    run_pass(1'b0, 8'h00, 16'h0200, 9, 8'hAA);
    read_chk("t3_pending", 8'h10, status_exp(1'b1));
    exp_data[9] = 8'hAA;
    run_pass(1'b0, 8'h00, 16'h0200, -1, 8'h00);

    // Clear-dirty command, then clear+force in one write
    cpu_write(8'h03, 8'h12);
    cpu_write(8'h10, 8'h02);
    read_chk("t4_status", 8'h10, status_exp(1'b0));
    run_pass(1'b0, 8'h00, 16'h0000, -1, 8'h00);
    read_chk("t4_readback", 8'h03, 8'h12);
    cpu_write(8'h01, 8'h77);
    run_pass(1'b1, 8'h03, 16'h0000, -1, 8'h00);
    read_chk("t4_both_status", 8'h10, status_exp(1'b0));

    // Control write and VSync edge while Busy are both dropped
    VSync = 1'b0;
    tick();
    VSync = 1'b1;
    pulses = 0;
    for (int j = 0; j < 16; j++) begin
      if (j == 8) begin
        Port_ID = 8'h02; IN_DATA = 8'h5A; CS_VGA = 1'b1; WRITE_STROBE = 1'b1;
      end
      if (j == 10) begin
        Port_ID = 8'h10; IN_DATA = 8'h03; CS_VGA = 1'b1; WRITE_STROBE = 1'b1;
      end
      if (j == 12) VSync = 1'b0;
      tick();
      CS_VGA = 1'b0; WRITE_STROBE = 1'b0; VSync = 1'b1;
      if (MemWE) pulses++;
    end
    check("t5_busy_pulses", pulses, 0);
    tick();
    exp_frame++;
    pulses = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (Busy) pulses++;
    end
    check("t5_no_requeue", pulses, 0);
    read_chk("t5_pending", 8'h10, status_exp(1'b1));
    exp_data[2] = 8'h5A;
    run_pass(1'b0, 8'h00, 16'h0004, -1, 8'h00);

    // Frame counter wrap 63 -> 0
    while (exp_frame[5:0] != 6'd63) quick_pass();
    read_chk("t5_frame63", 8'h10, 8'hFC);
    quick_pass();
    read_chk("t5_frame_wrap", 8'h10, 8'h00);

    // Reset in the middle of a pass
    cpu_write(8'h02, 8'h22);
    cpu_write(8'h0A, 8'hAA);
    VSync = 1'b0;
    tick();
    VSync = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    check("t6_pre_addr", 32'(MemAddrOut), 2);
    RESET = 1'b1;
    #1;
    check("t6_memaddr", 32'(MemAddrOut), 0);
    check("t6_memdata", 32'(MemDataIN), 0);
    check("t6_memwe", 32'(MemWE), 0);
    check("t6_busy", 32'(Busy), 0);
    check("t6_out_data", 32'(OUT_DATA), 0);
    tick();
    RESET = 1'b0;
    exp_frame = 0;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (MemWE || Busy) pulses++;
    end
    check("t6_no_resume", pulses, 0);
    read_chk("t6_status", 8'h10, 8'h00);
    read_chk("t6_shadow", 8'h0A, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_update_ctrl.md
# vga_frame_update_ctrl

Frame-synchronous bridge between the PicoBlaze port bus and the VGA pointer register memory (4-bit address, 8-bit data). CPU writes land in a 16-entry shadow file with per-entry dirty bits; on each vertical-sync assertion, or on a software force command, the controller scans the shadow file and replays dirty entries to the pointer memory, one write per cycle, so pointer changes never tear mid-frame. It also serves CPU readback of the shadow file and a status byte.

## Interface
- VSYNC_ACTIVE, 0: VSync level that means "sync asserted" (the sync generator drives VSync active-low).
- NUM_REGS, 16: shadow entries; fixed at 16 and matches the 4-bit memory address.
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Port_ID  input  8  PicoBlaze port address; only [4:0] decoded, [7:5] ignored.
- IN_DATA  input  8  PicoBlaze write data.
- WRITE_STROBE  input  1  PicoBlaze write strobe, one cycle.
- READ_STROBE  input  1  PicoBlaze read strobe; informational only, reads are non-destructive.
- CS_VGA  input  1  chip select from the upstream port decoder.
- OUT_DATA  output  8  registered readback data.
- VSync  input  1  vertical sync from the sync generator.
- MemAddrOut  output  4  pointer-memory write address.
- MemDataIN  output  8  pointer-memory write data.
- MemWE  output  1  pointer-memory write enable, one-cycle pulse per write.
- Busy  output  1  high while a commit pass runs.

## Operation
- Port map, active only when CS_VGA=1:
  - Port_ID[4]=0 selects shadow entry Port_ID[3:0] for read and write.
  - Port_ID[4:0]=0x10 reads status and writes control.
  - Other 0x11..0x1F: reads return 0x00, writes are ignored.
- Shadow write: when WRITE_STROBE=1, the entry takes IN_DATA and its dirty bit is set.
- Status byte: bit0 = Busy, bit1 = pending (OR of all dirty bits), bits[7:2] = frame_count[5:0].
- frame_count is 6 bits, increments once per completed pass and wraps 63 -> 0.
- Control write:
  - bit0: force commit.
  - bit1: clear all dirty bits.
  - Both are honoured only in IDLE and ignored while Busy.
  - If both bits are set in one write, dirty bits are cleared and an empty pass runs. frame_count still increments and MemWE never pulses.
- Trigger: VSync is registered into vs_q. An edge is detected when vs_q != VSYNC_ACTIVE and VSync == VSYNC_ACTIVE.
  - A trigger is a VSync edge or a force command.
  - A trigger in IDLE starts a pass. A trigger while Busy is dropped, not queued.
  - A VSync edge and a force in the same IDLE cycle start a single pass.
- FSM states:
  - IDLE: on trigger, go to SCAN with index k=0.
  - SCAN: visit entry k.
    - If dirty: MemAddrOut=k, MemDataIN=shadow[k], MemWE=1, and clear dirty[k].
    - Otherwise: MemWE=0.
    - k increments each cycle. After k=15, go to IDLE and increment frame_count.
- Collision, CPU write to entry i during SCAN:
  - If i > k (not yet scanned): the new value commits in this pass.
  - If i < k (already scanned): dirty[i] is set and the value commits next pass.
  - If i == k in the same cycle: the emitted data is the pre-write value, and set wins over clear so dirty[i] stays 1. The new value commits next pass.
- MemAddrOut and MemDataIN hold their last values when MemWE=0.

## Timing
- Reset values: OUT_DATA=0x00, MemAddrOut=0, MemDataIN=0x00, MemWE=0, Busy=0. All shadow entries 0x00, all dirty bits 0, frame_count=0, vs_q=~VSYNC_ACTIVE, state IDLE.
- RESET asserted mid-pass aborts the pass immediately. Remaining dirty entries are lost.
- Reads: OUT_DATA is registered from the Port_ID decode when CS_VGA=1, giving 1-cycle latency, and holds when CS_VGA=0.
- Trigger sampled at edge t:
  - Busy=1 from t+1 through t+16.
  - Entry k is emitted (MemWE, MemAddrOut, MemDataIN valid) at edge t+1+k.
  - Busy=0 and frame_count updated at edge t+17.
- A pass is always exactly 16 cycles, independent of dirty count.
- A shadow write at edge t is visible in readback on the next read cycle and its dirty bit is set at t.

## Test plan
- Reset, then write 0x3C to port 0x05, then assert VSync low -> exactly one MemWE pulse at pass cycle 5 with MemAddrOut=5 and MemDataIN=0x3C. Busy is high for 16 cycles, then status reads 0x04.
- Write entries 0, 7, and 15, then control 0x01 -> three MemWE pulses at pass cycles 0, 7, and 15. Pending=0 afterwards. A second VSync edge produces zero MemWE pulses.
- Write port 0x09 exactly at pass cycle 9 with new data 0xAA over old data 0x11 -> the pass emits 0x11. dirty[9] stays set and the next pass emits 0xAA.
- Write 0x12 to entry 3, then control 0x02 -> pending=0, and the next VSync pass has no MemWE pulses. Reading port 0x03 still returns 0x12 one cycle after selection.
- Run 64 force-commit passes -> the status frame field wraps to 0. A control write or a VSync edge during Busy is ignored.
- Assert RESET at pass cycle 4 with entries 2 and 10 dirty -> all outputs return to reset values, the pass does not resume, and status reads 0x00.
